// File: rtl/bit_serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder controller.
// The master side issues operations; the slave side (the adder) reports
// progress and holds the result.
interface bit_serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, acc, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, acc, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller.
// Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
// through a single one-bit full adder cell. Operand B is either the b input
// or the previous result (accumulate mode). The result is shifted into the
// sum register from the MSB end, so after WIDTH steps it sits aligned.

// One-bit full adder cell from the PE library; the controller instantiates
// it exactly once and routes every bit of every addition through it.
module pe_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_serial_add_ctrl_if.slave  bus
);

  // Bit counter only needs to reach WIDTH-1; WIDTH >= 2 keeps CW >= 1.
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;       // operand A shift register, consumed at bit 0
  logic [WIDTH-1:0] sb;       // operand B shift register, consumed at bit 0
  logic             cr;       // carry between successive bit steps
  logic [CW-1:0]    cnt;      // index of the bit being processed
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_co;

  // The single adder cell sees the current LSBs and the running carry.
  pe_full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cr),
    .s  (fa_s),
    .co (fa_co)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // Controller FSM plus datapath: state, shift registers, carry, counter
  // and the registered busy/done/sum/cout outputs all update together.
  // NOTE: every register here, including the shift registers, is cleared by
  // reset so an aborted operation leaves no stale operand bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cr     <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sum_q be read as an accumulate
      // operand on the same edge that any register here is updated.
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.acc ? sum_q : bus.b;
            cr     <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          cr    <= fa_co;
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_q <= fa_co;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
